// File: rtl/irq_request_controller_if.sv
// Signal bundle between the IRQ request front end and its surroundings.
// The master side drives the request lines and the acknowledge/EOI strobes.
// The slave side is the controller itself.
interface irq_request_controller_if #(
    parameter int NUM_IRQ = 8
);
    localparam int IDX_W = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_lines;
    logic [NUM_IRQ-1:0] trig_mode;
    logic [NUM_IRQ-1:0] imr;
    logic               inta_pulse;
    logic               eoi;
    logic               rotate_en;
    logic               int_out;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;
    logic [IDX_W-1:0]   vector_idx;
    logic               vector_valid;
    logic               spurious;

    modport master (
        output irq_lines, trig_mode, imr, inta_pulse, eoi, rotate_en,
        input  int_out, irr, isr, vector_idx, vector_valid, spurious
    );

    modport slave (
        input  irq_lines, trig_mode, imr, inta_pulse, eoi, rotate_en,
        output int_out, irr, isr, vector_idx, vector_valid, spurious
    );
endinterface

// File: rtl/irq_request_controller.sv
// 8259-style interrupt request front end.
// Synchronises raw IRQ lines, captures them into the IRR (edge or level),
// resolves priority against IMR/ISR with fixed or rotating order, runs the
// two-pulse INTA sequence and services non-specific EOI.
module irq_request_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    irq_request_controller_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_IRQ);

    typedef enum logic {
        IDLE,
        WAIT2
    } state_t;

    // Synchroniser stages, one vector per stage
    logic [NUM_IRQ-1:0] sync_p [SYNC_STAGES];
    logic [NUM_IRQ-1:0] hist_q;
    logic [NUM_IRQ-1:0] synced;
    logic [NUM_IRQ-1:0] rise;

    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] inta_set, inta_clr, eoi_clr;
    logic [IDX_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]   vidx_q, vidx_d;
    logic [IDX_W-1:0]   win_idx, top_idx;
    logic               win_vld, top_vld, nest_ok;
    logic               int_q, int_d;
    logic               vvld_q, vvld_d;
    logic               spur_q, spur_d;
    logic               spur_flag_q, spur_flag_d;
    state_t             state_q, state_d;

    // First set bit of vec walking b, b+1, ... modulo NUM_IRQ; MSB = found
    function automatic logic [IDX_W:0] pick_first(input logic [NUM_IRQ-1:0] vec,
                                                  input logic [IDX_W-1:0]   b);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            idx = (int'(b) + k) % NUM_IRQ;
            if (vec[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    // Position of idx in the current priority order (0 = highest)
    function automatic int rank(input logic [IDX_W-1:0] idx,
                                input logic [IDX_W-1:0] b);
        return (int'(idx) - int'(b) + NUM_IRQ) % NUM_IRQ;
    endfunction

    assign synced = sync_p[SYNC_STAGES-1];
    assign rise   = synced & ~hist_q;

    // Input synchroniser and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
            hist_q <= '0;
        end else begin
            sync_p[0] <= bus.irq_lines;
            for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
            hist_q <= synced;
        end
    end

    // Priority resolution: winning request and highest in-service channel
    always_comb begin
        cand               = irr_q & ~bus.imr;
        {win_vld, win_idx} = pick_first(cand, base_q);
        {top_vld, top_idx} = pick_first(isr_q, base_q);
        nest_ok            = win_vld &&
                             (!top_vld || (rank(win_idx, base_q) < rank(top_idx, base_q)));
    end

    // INTA sequencer: next state, acknowledge effects and CPU request
    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        spur_flag_d = spur_flag_q;
        vvld_d      = 1'b0;
        spur_d      = 1'b0;
        int_d       = 1'b0;
        inta_set    = '0;
        inta_clr    = '0;
        case (state_q)
            IDLE: begin
                if (bus.inta_pulse) begin
                    if (win_vld) begin
                        vidx_d   = win_idx;
                        inta_set = NUM_IRQ'(1) << win_idx;
                        // level channels keep following the line
                        inta_clr = inta_set & ~bus.trig_mode;
                    end else begin
                        vidx_d      = IDX_W'(NUM_IRQ - 1);
                        spur_flag_d = 1'b1;
                    end
                    state_d = WAIT2;
                end else begin
                    int_d = nest_ok;
                end
            end
            WAIT2: begin
                if (bus.inta_pulse) begin
                    vvld_d      = 1'b1;
                    spur_d      = spur_flag_q;
                    spur_flag_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EOI on the pre-update ISR, then INTA set; request capture with set winning
    always_comb begin
        eoi_clr = '0;
        base_d  = base_q;
        if (bus.eoi && top_vld) begin
            eoi_clr = NUM_IRQ'(1) << top_idx;
            if (bus.rotate_en) base_d = IDX_W'((int'(top_idx) + 1) % NUM_IRQ);
        end
        isr_d = (isr_q & ~eoi_clr) | inta_set;
        irr_d = (bus.trig_mode & synced) |
                (~bus.trig_mode & ((irr_q & ~inta_clr) | rise));
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irr_q       <= '0;
            isr_q       <= '0;
            base_q      <= '0;
            vidx_q      <= '0;
            int_q       <= 1'b0;
            vvld_q      <= 1'b0;
            spur_q      <= 1'b0;
            spur_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            base_q      <= base_d;
            vidx_q      <= vidx_d;
            int_q       <= int_d;
            vvld_q      <= vvld_d;
            spur_q      <= spur_d;
            spur_flag_q <= spur_flag_d;
        end
    end

    assign bus.int_out      = int_q;
    assign bus.irr          = irr_q;
    assign bus.isr          = isr_q;
    assign bus.vector_idx   = vidx_q;
    assign bus.vector_valid = vvld_q;
    assign bus.spurious     = spur_q;

endmodule

// File: tb/tb_irq_request_controller.sv
// Bench for irq_request_controller: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_irq_request_controller;

    localparam int N    = 8;
    localparam int SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    irq_request_controller_if #(.NUM_IRQ(N))  bus ();
    irq_request_controller_if #(.NUM_IRQ(16)) bus16 ();

    irq_request_controller #(.NUM_IRQ(N), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    irq_request_controller #(.NUM_IRQ(16), .SYNC_STAGES(SYNC)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Behavioural model state
    logic [N-1:0] dly [SYNC+1];
    logic [N-1:0] m_irr, m_isr, s_sync, s_prev, n_irr, n_isr;
    int           m_base, m_vidx, win, wr, top, tr;
    bit           m_wait, m_flag;
    logic         m_int, m_vv, m_sp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] exp);
        check(name, dut_v, exp);
        check({name, "/model"}, mdl_v, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inta();
        bus.inta_pulse = 1'b1;
        tick(1);
        bus.inta_pulse = 1'b0;
    endtask

    task automatic eoi_s();
        bus.eoi = 1'b1;
        tick(1);
        bus.eoi = 1'b0;
    endtask

    task automatic inta16();
        bus16.inta_pulse = 1'b1;
        tick(1);
        bus16.inta_pulse = 1'b0;
    endtask

    task automatic eoi16();
        bus16.eoi = 1'b1;
        tick(1);
        bus16.eoi = 1'b0;
    endtask

    // Reference model: lines seen SYNC cycles late, rank-based priority
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= SYNC; k++) dly[k] = '0;
            m_irr = '0; m_isr = '0; m_base = 0; m_vidx = 0;
            m_wait = 1'b0; m_flag = 1'b0; m_int = 1'b0; m_vv = 1'b0; m_sp = 1'b0;
        end else begin
            s_sync = dly[SYNC-1];
            s_prev = dly[SYNC];
            win = -1; wr = N; top = -1; tr = N;
            for (int i = 0; i < N; i++) begin
                int r;
                r = (i - m_base + N) % N;
                if (m_irr[i] && !bus.imr[i] && r < wr) begin wr = r; win = i; end
                if (m_isr[i] && r < tr) begin tr = r; top = i; end
            end
            n_irr = m_irr;
            n_isr = m_isr;
            m_vv  = 1'b0;
            m_sp  = 1'b0;
            m_int = 1'b0;
            if (bus.eoi && top >= 0) begin
                n_isr[top] = 1'b0;
                if (bus.rotate_en) m_base = (top + 1) % N;
            end
            if (!m_wait) begin
                if (bus.inta_pulse) begin
                    if (win >= 0) begin
                        m_vidx = win;
                        n_isr[win] = 1'b1;
                        if (!bus.trig_mode[win]) n_irr[win] = 1'b0;
                    end else begin
                        m_vidx = N - 1;
                        m_flag = 1'b1;
                    end
                    m_wait = 1'b1;
                end else begin
                    m_int = (win >= 0) && (top < 0 || wr < tr);
                end
            end else if (bus.inta_pulse) begin
                m_vv   = 1'b1;
                m_sp   = m_flag;
                m_flag = 1'b0;
                m_wait = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.trig_mode[i]) n_irr[i] = s_sync[i];
                else if (s_sync[i] && !s_prev[i]) n_irr[i] = 1'b1;
            end
            m_irr = n_irr;
            m_isr = n_isr;
            for (int k = SYNC; k > 0; k--) dly[k] = dly[k-1];
            dly[0] = bus.irq_lines;
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_int_out",  32'(bus.int_out),      32'(m_int));
            check("cmp_irr",      32'(bus.irr),          32'(m_irr));
            check("cmp_isr",      32'(bus.isr),          32'(m_isr));
            check("cmp_vidx",     32'(bus.vector_idx),   32'(m_vidx));
            check("cmp_vvalid",   32'(bus.vector_valid), 32'(m_vv));
            check("cmp_spurious", 32'(bus.spurious),     32'(m_sp));
        end
    end

    initial begin
        bus.irq_lines = '0; bus.trig_mode = '0; bus.imr = '0;
        bus.inta_pulse = 1'b0; bus.eoi = 1'b0; bus.rotate_en = 1'b0;
        bus16.irq_lines = '0; bus16.trig_mode = '0; bus16.imr = '0;
        bus16.inta_pulse = 1'b0; bus16.eoi = 1'b0; bus16.rotate_en = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        lit("rst_irr",  32'(bus.irr),        32'(m_irr), 0);
        lit("rst_isr",  32'(bus.isr),        32'(m_isr), 0);
        lit("rst_int",  32'(bus.int_out),    32'(m_int), 0);
        lit("rst_vidx", 32'(bus.vector_idx), 32'(m_vidx), 0);
        lit("rst_vv",   32'(bus.vector_valid), 32'(m_vv), 0);
        tick(1);
        #2 rst_n = 1'b1;
        run_cmp = 1'b1;

        // edge capture on IRQ3
        tick(1);
        bus.irq_lines[3] = 1'b1;
        tick(2);
        lit("edge_irr_early", 32'(bus.irr), 32'(m_irr), 0);
        tick(1);
        lit("edge_irr",       32'(bus.irr), 32'(m_irr), 32'h08);
        lit("edge_int_early", 32'(bus.int_out), 32'(m_int), 0);
        tick(1);
        lit("edge_int",       32'(bus.int_out), 32'(m_int), 1);
        inta();
        lit("edge_isr",       32'(bus.isr), 32'(m_isr), 32'h08);
        lit("edge_irr_clr",   32'(bus.irr), 32'(m_irr), 0);
        lit("edge_vidx",      32'(bus.vector_idx), 32'(m_vidx), 3);
        lit("edge_int_drop",  32'(bus.int_out), 32'(m_int), 0);
        tick(1);
        inta();
        lit("edge_vv",        32'(bus.vector_valid), 32'(m_vv), 1);
        lit("edge_sp",        32'(bus.spurious), 32'(m_sp), 0);
        tick(1);
        lit("edge_vv_pulse",  32'(bus.vector_valid), 32'(m_vv), 0);
        tick(4);
        lit("edge_no_rereq",  32'(bus.irr), 32'(m_irr), 0);
        eoi_s();
        lit("edge_eoi",       32'(bus.isr), 32'(m_isr), 0);
        bus.irq_lines = '0;
        tick(4);

        // level mode on IRQ5
        bus.trig_mode = 8'h20;
        bus.irq_lines[5] = 1'b1;
        tick(3);
        lit("lvl_irr",        32'(bus.irr), 32'(m_irr), 32'h20);
        tick(1);
        lit("lvl_int",        32'(bus.int_out), 32'(m_int), 1);
        inta();
        lit("lvl_isr",        32'(bus.isr), 32'(m_isr), 32'h20);
        lit("lvl_irr_held",   32'(bus.irr), 32'(m_irr), 32'h20);
        tick(1);
        inta();
        lit("lvl_vidx",       32'(bus.vector_idx), 32'(m_vidx), 5);
        tick(2);
        lit("lvl_int_equal",  32'(bus.int_out), 32'(m_int), 0);
        eoi_s();
        lit("lvl_eoi",        32'(bus.isr), 32'(m_isr), 0);
        tick(1);
        lit("lvl_rereq",      32'(bus.int_out), 32'(m_int), 1);
        bus.irq_lines = '0;
        tick(3);
        lit("lvl_irr_low",    32'(bus.irr), 32'(m_irr), 0);
        tick(2);
        bus.trig_mode = '0;

        // nesting: IRQ2 in service, IRQ6 and IRQ1 requested
        bus.irq_lines[2] = 1'b1;
        tick(4); inta(); tick(1); inta();
        bus.irq_lines = '0;
        lit("nest_isr2",      32'(bus.isr), 32'(m_isr), 32'h04);
        bus.irq_lines[6] = 1'b1;
        bus.irq_lines[1] = 1'b1;
        tick(4);
        lit("nest_irr",       32'(bus.irr), 32'(m_irr), 32'h42);
        lit("nest_int",       32'(bus.int_out), 32'(m_int), 1);
        inta();
        lit("nest_vidx",      32'(bus.vector_idx), 32'(m_vidx), 1);
        lit("nest_isr",       32'(bus.isr), 32'(m_isr), 32'h06);
        tick(1); inta(); tick(2);
        lit("nest_int_low",   32'(bus.int_out), 32'(m_int), 0);
        eoi_s();
        lit("nest_eoi1",      32'(bus.isr), 32'(m_isr), 32'h04);
        tick(2);
        lit("nest_int_blk",   32'(bus.int_out), 32'(m_int), 0);
        eoi_s();
        tick(1);
        lit("nest_int_free",  32'(bus.int_out), 32'(m_int), 1);
        inta(); tick(1); inta();
        lit("nest_vidx6",     32'(bus.vector_idx), 32'(m_vidx), 6);
        eoi_s();
        bus.irq_lines = '0;
        tick(4);

        // masked request and spurious acknowledge
        bus.imr = 8'hFF;
        bus.irq_lines[0] = 1'b1;
        tick(4);
        lit("mask_irr",       32'(bus.irr), 32'(m_irr), 1);
        lit("mask_int",       32'(bus.int_out), 32'(m_int), 0);
        inta();
        lit("spur_vidx",      32'(bus.vector_idx), 32'(m_vidx), 7);
        tick(1); inta();
        lit("spur_vv",        32'(bus.vector_valid), 32'(m_vv), 1);
        lit("spur_flag",      32'(bus.spurious), 32'(m_sp), 1);
        lit("spur_isr",       32'(bus.isr), 32'(m_isr), 0);
        bus.imr = '0;
        tick(2);
        lit("unmask_int",     32'(bus.int_out), 32'(m_int), 1);
        inta(); tick(1); inta(); eoi_s();
        bus.irq_lines = '0;
        tick(4);

        // EOI and first INTA in the same cycle
        bus.irq_lines[2] = 1'b1;
        tick(4); inta(); tick(1); inta();
        bus.irq_lines = '0;
        bus.irq_lines[1] = 1'b1;
        tick(4);
        bus.eoi = 1'b1;
        bus.inta_pulse = 1'b1;
        tick(1);
        bus.eoi = 1'b0;
        bus.inta_pulse = 1'b0;
        lit("simul_isr",      32'(bus.isr), 32'(m_isr), 32'h02);
        lit("simul_vidx",     32'(bus.vector_idx), 32'(m_vidx), 1);
        tick(1); inta(); eoi_s();
        bus.irq_lines = '0;
        tick(4);

        // reset while waiting for the second INTA
        bus.irq_lines[3] = 1'b1;
        tick(4); inta();
        bus.irq_lines = '0;
        #2 rst_n = 1'b0;
        #1;
        lit("mrst_isr",       32'(bus.isr), 32'(m_isr), 0);
        lit("mrst_vidx",      32'(bus.vector_idx), 32'(m_vidx), 0);
        lit("mrst_int",       32'(bus.int_out), 32'(m_int), 0);
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
        inta();
        lit("mrst_no_vv",     32'(bus.vector_valid), 32'(m_vv), 0);
        tick(1); inta();
        lit("mrst_spur",      32'(bus.spurious), 32'(m_sp), 1);

        // automatic rotation
        bus.rotate_en = 1'b1;
        bus.irq_lines[0] = 1'b1;
        tick(4); inta(); tick(1); inta(); eoi_s();
        bus.irq_lines = '0;
        tick(4);
        bus.irq_lines = 8'h11;
        tick(4);
        inta();
        lit("rot_winner",     32'(bus.vector_idx), 32'(m_vidx), 4);
        tick(1); inta(); eoi_s();
        tick(1); inta();
        lit("rot_next",       32'(bus.vector_idx), 32'(m_vidx), 0);
        tick(1); inta(); eoi_s();
        bus.irq_lines = '0;
        bus.rotate_en = 1'b0;
        tick(4);

        // base wrap with 16 channels
        bus16.rotate_en = 1'b1;
        bus16.irq_lines[3] = 1'b1;
        tick(4); inta16(); tick(1); inta16();
        check("w16_first", 32'(bus16.vector_idx), 3);
        eoi16();
        bus16.irq_lines = '0;
        tick(2);
        bus16.irq_lines[15] = 1'b1;
        tick(4); inta16(); tick(1); inta16();
        check("w16_irq15", 32'(bus16.vector_idx), 15);
        eoi16();
        bus16.irq_lines = '0;
        tick(2);
        bus16.irq_lines = 16'h0022;
        tick(4); inta16();
        check("w16_wrap", 32'(bus16.vector_idx), 1);
        tick(1); inta16(); eoi16();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] flip;
            flip = N'($urandom) & N'($urandom) & N'($urandom);
            bus.irq_lines = bus.irq_lines ^ flip;
            if ($urandom_range(0, 63) == 0) bus.trig_mode = N'($urandom);
            if ($urandom_range(0, 63) == 0) bus.imr = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 127) == 0) bus.rotate_en = 1'($urandom_range(0, 1));
            bus.inta_pulse = ($urandom_range(0, 5) == 0);
            bus.eoi = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        bus.inta_pulse = 1'b0;
        bus.eoi = 1'b0;
        tick(2);
        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
